// File: rtl/mac_tx_arbiter.sv
// rtl/mac_tx_arbiter.sv - packet-granular 2:1 ARP/IP arbiter feeding the MAC transmit stream
// Optional feature: define MAC_TX_ARB_RR_EN for round-robin tie-break (default: fixed ARP priority).
module mac_tx_arbiter #(
  parameter int P_DATA_W = 64,
  parameter int P_USER_W = 80,
  parameter int P_CNT_W  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [P_DATA_W-1:0]   s_axis_arp_data,
  input  logic [P_USER_W-1:0]   s_axis_arp_user,
  input  logic [P_DATA_W/8-1:0] s_axis_arp_keep,
  input  logic                  s_axis_arp_last,
  input  logic                  s_axis_arp_valid,
  output logic                  s_axis_arp_ready,
  input  logic [P_DATA_W-1:0]   s_axis_ip_data,
  input  logic [P_USER_W-1:0]   s_axis_ip_user,
  input  logic [P_DATA_W/8-1:0] s_axis_ip_keep,
  input  logic                  s_axis_ip_last,
  input  logic                  s_axis_ip_valid,
  output logic                  s_axis_ip_ready,
  output logic [P_DATA_W-1:0]   m_axis_mac_data,
  output logic [P_USER_W-1:0]   m_axis_mac_user,
  output logic [P_DATA_W/8-1:0] m_axis_mac_keep,
  output logic                  m_axis_mac_last,
  output logic                  m_axis_mac_valid,
  input  logic                  m_axis_mac_ready,
  output logic [P_CNT_W-1:0]    o_arp_pkt_cnt,
  output logic [P_CNT_W-1:0]    o_ip_pkt_cnt,
  output logic                  o_busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_ARP, ST_IP} state_t;

  state_t     state, state_nxt;
  logic [1:0] rst_pipe;
  logic       rst_n;
  logic       slot_free;
  logic       tie_arp;
  logic       arp_acc, ip_acc;

  // Reset asserts asynchronously everywhere but is released in step with i_clk.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) rst_pipe <= 2'b00;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_n = rst_pipe[1];

`ifdef MAC_TX_ARB_RR_EN
  logic last_grant_arp;

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n)
      last_grant_arp <= 1'b0;
    else if (state == ST_IDLE && state_nxt != ST_IDLE)
      last_grant_arp <= (state_nxt == ST_ARP);
  end
  assign tie_arp = !last_grant_arp;
`else
  assign tie_arp = 1'b1;
`endif

  assign slot_free = !m_axis_mac_valid || m_axis_mac_ready;

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    s_axis_arp_ready = 1'b0;
    s_axis_ip_ready  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (s_axis_arp_valid && s_axis_ip_valid) state_nxt = tie_arp ? ST_ARP : ST_IP;
        else if (s_axis_arp_valid)               state_nxt = ST_ARP;
        else if (s_axis_ip_valid)                state_nxt = ST_IP;
      end
      ST_ARP: begin
        s_axis_arp_ready = slot_free;
        if (s_axis_arp_valid && slot_free && s_axis_arp_last) state_nxt = ST_IDLE;
      end
      ST_IP: begin
        s_axis_ip_ready = slot_free;
        if (s_axis_ip_valid && slot_free && s_axis_ip_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign arp_acc = s_axis_arp_valid && s_axis_arp_ready;
  assign ip_acc  = s_axis_ip_valid && s_axis_ip_ready;

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_mac_valid <= 1'b0;
      m_axis_mac_data  <= '0;
      m_axis_mac_user  <= '0;
      m_axis_mac_keep  <= '0;
      m_axis_mac_last  <= 1'b0;
    end else if (arp_acc) begin
      m_axis_mac_valid <= 1'b1;
      m_axis_mac_data  <= s_axis_arp_data;
      m_axis_mac_user  <= s_axis_arp_user;
      m_axis_mac_keep  <= s_axis_arp_keep;
      m_axis_mac_last  <= s_axis_arp_last;
    end else if (ip_acc) begin
      m_axis_mac_valid <= 1'b1;
      m_axis_mac_data  <= s_axis_ip_data;
      m_axis_mac_user  <= s_axis_ip_user;
      m_axis_mac_keep  <= s_axis_ip_keep;
      m_axis_mac_last  <= s_axis_ip_last;
    end else if (m_axis_mac_ready) begin
      m_axis_mac_valid <= 1'b0;
    end
  end

  // Counts on input acceptance of the last beat, not on the output handshake.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      o_arp_pkt_cnt <= '0;
      o_ip_pkt_cnt  <= '0;
    end else begin
      if (arp_acc && s_axis_arp_last) o_arp_pkt_cnt <= o_arp_pkt_cnt + P_CNT_W'(1);
      if (ip_acc && s_axis_ip_last)   o_ip_pkt_cnt  <= o_ip_pkt_cnt + P_CNT_W'(1);
    end
  end

  assign o_busy = (state != ST_IDLE) || m_axis_mac_valid;

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// tb/tb_mac_tx_arbiter.sv - randomized self-checking bench for mac_tx_arbiter
module tb_mac_tx_arbiter;
  localparam int DW = 64;
  localparam int UW = 80;
  localparam int CW = 8;

  typedef struct {
    logic [DW-1:0]   data;
    logic [UW-1:0]   user;
    logic [DW/8-1:0] keep;
    logic            last;
  } beat_t;

  logic            i_clk, i_rst;
  logic [DW-1:0]   s_axis_arp_data, s_axis_ip_data, m_axis_mac_data;
  logic [UW-1:0]   s_axis_arp_user, s_axis_ip_user, m_axis_mac_user;
  logic [DW/8-1:0] s_axis_arp_keep, s_axis_ip_keep, m_axis_mac_keep;
  logic            s_axis_arp_last, s_axis_arp_valid, s_axis_arp_ready;
  logic            s_axis_ip_last, s_axis_ip_valid, s_axis_ip_ready;
  logic            m_axis_mac_last, m_axis_mac_valid, m_axis_mac_ready;
  logic [CW-1:0]   o_arp_pkt_cnt, o_ip_pkt_cnt;
  logic            o_busy;

  mac_tx_arbiter #(.P_DATA_W(DW), .P_USER_W(UW), .P_CNT_W(CW)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .s_axis_arp_data(s_axis_arp_data), .s_axis_arp_user(s_axis_arp_user),
    .s_axis_arp_keep(s_axis_arp_keep), .s_axis_arp_last(s_axis_arp_last),
    .s_axis_arp_valid(s_axis_arp_valid), .s_axis_arp_ready(s_axis_arp_ready),
    .s_axis_ip_data(s_axis_ip_data), .s_axis_ip_user(s_axis_ip_user),
    .s_axis_ip_keep(s_axis_ip_keep), .s_axis_ip_last(s_axis_ip_last),
    .s_axis_ip_valid(s_axis_ip_valid), .s_axis_ip_ready(s_axis_ip_ready),
    .m_axis_mac_data(m_axis_mac_data), .m_axis_mac_user(m_axis_mac_user),
    .m_axis_mac_keep(m_axis_mac_keep), .m_axis_mac_last(m_axis_mac_last),
    .m_axis_mac_valid(m_axis_mac_valid), .m_axis_mac_ready(m_axis_mac_ready),
    .o_arp_pkt_cnt(o_arp_pkt_cnt), .o_ip_pkt_cnt(o_ip_pkt_cnt), .o_busy(o_busy)
  );

  beat_t arp_q[$], ip_q[$], out_q[$];
  beat_t mdl_arp[$], mdl_ip[$], mdl_exp[$];
  int    out_cyc[$];
  int    cyc = 0;
  bit    arp_acc_s = 0, ip_acc_s = 0, rand_ready = 0;
  int    n_checks = 0, n_pass = 0;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Source drivers and MAC-side backpressure, updated just after each rising edge.
  initial begin
    forever begin
      @(posedge i_clk);
      cyc++;
      #1;
      if (arp_acc_s && arp_q.size() > 0) arp_q.delete(0);
      if (ip_acc_s && ip_q.size() > 0) ip_q.delete(0);
      s_axis_arp_valid = arp_q.size() > 0;
      if (arp_q.size() > 0) begin
        s_axis_arp_data = arp_q[0].data; s_axis_arp_user = arp_q[0].user;
        s_axis_arp_keep = arp_q[0].keep; s_axis_arp_last = arp_q[0].last;
      end
      s_axis_ip_valid = ip_q.size() > 0;
      if (ip_q.size() > 0) begin
        s_axis_ip_data = ip_q[0].data; s_axis_ip_user = ip_q[0].user;
        s_axis_ip_keep = ip_q[0].keep; s_axis_ip_last = ip_q[0].last;
      end
      m_axis_mac_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Handshake observer on the falling edge.
  initial begin
    forever begin
      beat_t b;
      @(negedge i_clk);
      arp_acc_s = s_axis_arp_valid && s_axis_arp_ready;
      ip_acc_s  = s_axis_ip_valid && s_axis_ip_ready;
      if (m_axis_mac_valid && m_axis_mac_ready) begin
        b.data = m_axis_mac_data; b.user = m_axis_mac_user;
        b.keep = m_axis_mac_keep; b.last = m_axis_mac_last;
        out_q.push_back(b);
        out_cyc.push_back(cyc);
      end
    end
  end

  task automatic push_pkt(input bit is_arp, input int n, input logic [7:0] last_keep);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = {$urandom, $urandom};
      b.data[63:60] = is_arp ? 4'hA : 4'h5;
      b.user = {16'($urandom), $urandom, $urandom};
      b.last = (i == n - 1);
      b.keep = b.last ? last_keep : 8'hFF;
      if (is_arp) begin arp_q.push_back(b); mdl_arp.push_back(b); end
      else begin ip_q.push_back(b); mdl_ip.push_back(b); end
    end
  endtask

  // Packet-level reference: whole packets move to the output in grant order.
  task automatic model_order();
    beat_t b;
    bit    pick_arp;
`ifdef MAC_TX_ARB_RR_EN
    bit    last_arp = 1'b0;
`endif
    while (mdl_arp.size() > 0 || mdl_ip.size() > 0) begin
      if (mdl_arp.size() > 0 && mdl_ip.size() > 0) begin
`ifdef MAC_TX_ARB_RR_EN
        pick_arp = !last_arp;
`else
        pick_arp = 1'b1;
`endif
      end else begin
        pick_arp = mdl_arp.size() > 0;
      end
`ifdef MAC_TX_ARB_RR_EN
      last_arp = pick_arp;
`endif
      do begin
        b = pick_arp ? mdl_arp.pop_front() : mdl_ip.pop_front();
        mdl_exp.push_back(b);
      end while (!b.last);
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b0;
    rand_ready = 0;
    @(negedge i_clk);
    arp_q.delete(); ip_q.delete();
    mdl_arp.delete(); mdl_ip.delete(); mdl_exp.delete();
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1;
    repeat (4) @(posedge i_clk);
    @(negedge i_clk);
    out_q.delete(); out_cyc.delete();
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge i_clk);
      if (arp_q.size() == 0 && ip_q.size() == 0 && !o_busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (m_axis_mac_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", m_axis_mac_valid); else n_pass++;
    n_checks++; if ({m_axis_mac_data, m_axis_mac_user, m_axis_mac_keep, m_axis_mac_last} !== '0)
      $display("FAIL rst_out_regs: got %h want 0", {m_axis_mac_data, m_axis_mac_user, m_axis_mac_keep, m_axis_mac_last}); else n_pass++;
    n_checks++; if ({s_axis_arp_ready, s_axis_ip_ready} !== 2'b00) $display("FAIL rst_ready: got %b want 00", {s_axis_arp_ready, s_axis_ip_ready}); else n_pass++;
    n_checks++; if ({o_arp_pkt_cnt, o_ip_pkt_cnt} !== '0) $display("FAIL rst_cnt: got %h want 0", {o_arp_pkt_cnt, o_ip_pkt_cnt}); else n_pass++;
    n_checks++; if (o_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", o_busy); else n_pass++;
  endtask

  task automatic test_single_arp();
    int c0; bit ok;
    do_reset();
    c0 = cyc;
    push_pkt(1'b1, 6, 8'h03);
    model_order();
    @(negedge i_clk);
    n_checks++; if (s_axis_arp_ready !== 1'b0) $display("FAIL arb_cycle_ready: got %b want 0", s_axis_arp_ready); else n_pass++;
    @(negedge i_clk);
    n_checks++; if (s_axis_arp_ready !== 1'b1) $display("FAIL grant_ready: got %b want 1", s_axis_arp_ready); else n_pass++;
    wait_drain(100, ok);
    n_checks++; if (!ok) $display("FAIL single_drain: got timeout want drained"); else n_pass++;
    n_checks++; if (out_q.size() != 6) $display("FAIL single_len: got %0d want 6", out_q.size()); else n_pass++;
    for (int i = 0; i < 6 && i < out_q.size(); i++) begin
      n_checks++; if (out_q[i] != mdl_exp[i]) $display("FAIL single_beat%0d: got %h want %h", i, out_q[i].data, mdl_exp[i].data); else n_pass++;
      n_checks++; if (out_cyc[i] != c0 + 3 + i) $display("FAIL single_cyc%0d: got %0d want %0d", i, out_cyc[i], c0 + 3 + i); else n_pass++;
    end
    n_checks++; if (o_arp_pkt_cnt !== 8'd1 || o_ip_pkt_cnt !== 8'd0)
      $display("FAIL single_cnt: got %0d/%0d want 1/0", o_arp_pkt_cnt, o_ip_pkt_cnt); else n_pass++;
  endtask

  task automatic test_ip_then_arp();
    int viol = 0; int gap; bit ok;
    do_reset();
    push_pkt(1'b0, 10, 8'hFF);
    for (int i = 0; i < 200 && out_q.size() < 3; i++) @(negedge i_clk);
    push_pkt(1'b1, 4, 8'h0F);
    while (mdl_ip.size() > 0) mdl_exp.push_back(mdl_ip.pop_front());
    while (mdl_arp.size() > 0) mdl_exp.push_back(mdl_arp.pop_front());
    for (int i = 0; i < 200 && out_q.size() < 10; i++) begin
      @(negedge i_clk);
      if (s_axis_arp_ready) viol++;
    end
    n_checks++; if (viol != 0) $display("FAIL arp_ready_during_ip: got %0d cycles want 0", viol); else n_pass++;
    wait_drain(200, ok);
    n_checks++; if (!ok || out_q.size() != 14) $display("FAIL preempt_len: got %0d want 14", out_q.size()); else n_pass++;
    for (int i = 0; i < 14 && i < out_q.size(); i++) begin
      n_checks++; if (out_q[i] != mdl_exp[i]) $display("FAIL preempt_beat%0d: got %h want %h", i, out_q[i].data, mdl_exp[i].data); else n_pass++;
    end
    if (out_cyc.size() >= 11) begin
      gap = out_cyc[10] - out_cyc[9];
      n_checks++; if (gap != 2) $display("FAIL preempt_bubble: got %0d want 2", gap); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int arp_first8 = 0; bit ok;
    do_reset();
    for (int p = 0; p < 8; p++) begin push_pkt(1'b1, 2, 8'hFF); push_pkt(1'b0, 2, 8'hFF); end
    model_order();
    wait_drain(400, ok);
    n_checks++; if (!ok || out_q.size() != 32) $display("FAIL b2b_len: got %0d want 32", out_q.size()); else n_pass++;
    for (int i = 0; i < 32 && i < out_q.size(); i++) begin
      n_checks++; if (out_q[i] != mdl_exp[i]) $display("FAIL b2b_beat%0d: got %h want %h", i, out_q[i].data, mdl_exp[i].data); else n_pass++;
      if (i < 16 && out_q[i].last && out_q[i].data[63:60] == 4'hA) arp_first8++;
    end
`ifdef MAC_TX_ARB_RR_EN
    n_checks++; if (arp_first8 != 4) $display("FAIL b2b_arp_share: got %0d want 4", arp_first8); else n_pass++;
`else
    n_checks++; if (arp_first8 != 8) $display("FAIL b2b_arp_share: got %0d want 8", arp_first8); else n_pass++;
`endif
    for (int i = 1; i < 16 && i < out_cyc.size(); i += 2) begin
      n_checks++; if (out_cyc[i] - out_cyc[i-1] != 1) $display("FAIL b2b_rate%0d: got %0d want 1", i, out_cyc[i] - out_cyc[i-1]); else n_pass++;
    end
    n_checks++; if (o_arp_pkt_cnt !== 8'd8 || o_ip_pkt_cnt !== 8'd8)
      $display("FAIL b2b_cnt: got %0d/%0d want 8/8", o_arp_pkt_cnt, o_ip_pkt_cnt); else n_pass++;
  endtask

  task automatic test_stall();
    beat_t snap; bit prev_stall = 0; bit ok = 0; int hold_bad = 0;
    do_reset();
    push_pkt(1'b0, 20, 8'h7F);
    model_order();
    rand_ready = 1;
    for (int i = 0; i < 400; i++) begin
      @(negedge i_clk);
      if (prev_stall && (!m_axis_mac_valid || m_axis_mac_data !== snap.data || m_axis_mac_user !== snap.user ||
                         m_axis_mac_keep !== snap.keep || m_axis_mac_last !== snap.last)) hold_bad++;
      prev_stall = m_axis_mac_valid && !m_axis_mac_ready;
      snap.data = m_axis_mac_data; snap.user = m_axis_mac_user;
      snap.keep = m_axis_mac_keep; snap.last = m_axis_mac_last;
      if (ip_q.size() == 0 && !o_busy) begin ok = 1; break; end
    end
    rand_ready = 0;
    n_checks++; if (hold_bad != 0) $display("FAIL stall_hold: got %0d unstable cycles want 0", hold_bad); else n_pass++;
    n_checks++; if (!ok || out_q.size() != 20) $display("FAIL stall_len: got %0d want 20", out_q.size()); else n_pass++;
    for (int i = 0; i < 20 && i < out_q.size(); i++) begin
      n_checks++; if (out_q[i] != mdl_exp[i]) $display("FAIL stall_beat%0d: got %h want %h", i, out_q[i].data, mdl_exp[i].data); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    push_pkt(1'b1, 8, 8'hFF);
    for (int i = 0; i < 100 && out_q.size() < 4; i++) @(negedge i_clk);
    #2 i_rst = 1'b0;
    #1;
    n_checks++; if (m_axis_mac_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", m_axis_mac_valid); else n_pass++;
    n_checks++; if (o_arp_pkt_cnt !== 8'd0 || o_ip_pkt_cnt !== 8'd0)
      $display("FAIL midrst_cnt: got %0d/%0d want 0/0", o_arp_pkt_cnt, o_ip_pkt_cnt); else n_pass++;
    do_reset();
    push_pkt(1'b1, 3, 8'h01);
    model_order();
    wait_drain(100, ok);
    n_checks++; if (!ok || out_q.size() != 3) $display("FAIL midrst_len: got %0d want 3", out_q.size()); else n_pass++;
    for (int i = 0; i < 3 && i < out_q.size(); i++) begin
      n_checks++; if (out_q[i] != mdl_exp[i]) $display("FAIL midrst_beat%0d: got %h want %h", i, out_q[i].data, mdl_exp[i].data); else n_pass++;
    end
    n_checks++; if (o_arp_pkt_cnt !== 8'd1) $display("FAIL midrst_arp_cnt: got %0d want 1", o_arp_pkt_cnt); else n_pass++;
  endtask

  task automatic test_counter_wrap();
    bit ok;
    do_reset();
    for (int p = 0; p < 255; p++) push_pkt(1'b0, 1, 8'($urandom));
    wait_drain(2000, ok);
    n_checks++; if (!ok || o_ip_pkt_cnt !== 8'hFF) $display("FAIL wrap_full: got %0d want 255", o_ip_pkt_cnt); else n_pass++;
    push_pkt(1'b0, 1, 8'h80);
    wait_drain(100, ok);
    n_checks++; if (!ok || o_ip_pkt_cnt !== 8'h00) $display("FAIL wrap_zero: got %0d want 0", o_ip_pkt_cnt); else n_pass++;
    n_checks++; if (out_q.size() != 256) $display("FAIL wrap_beats: got %0d want 256", out_q.size()); else n_pass++;
    n_checks++; if (o_arp_pkt_cnt !== 8'd0) $display("FAIL wrap_arp_cnt: got %0d want 0", o_arp_pkt_cnt); else n_pass++;
  endtask

  initial begin
    i_rst = 1'b0;
    s_axis_arp_valid = 0; s_axis_arp_data = '0; s_axis_arp_user = '0; s_axis_arp_keep = '0; s_axis_arp_last = 0;
    s_axis_ip_valid = 0;  s_axis_ip_data = '0;  s_axis_ip_user = '0;  s_axis_ip_keep = '0;  s_axis_ip_last = 0;
    m_axis_mac_ready = 1'b1;
    test_reset();
    test_single_arp();
    test_ip_then_arp();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_counter_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mac_tx_arbiter.md
# mac_tx_arbiter

Packet-granular 2:1 arbiter on the transmit path, directly downstream of the ARP block's `m_axis_arp_*` stream and the IP/UDP transmit stream. It picks one source per packet, forwards every beat unmodified through a single registered output stage, and feeds the 10G MAC transmit interface. Per-source sent-packet counters are kept for status.

## Interface
Parameters:
- `P_DATA_W`, 64, data width (keep width = `P_DATA_W/8`)
- `P_USER_W`, 80, sideband user width, passed through untouched
- `P_CNT_W`, 16, width of packet counters

Ports:
- `i_clk` input 1: single clock for all logic.
- `i_rst` input 1: reset, asynchronous, active-low.
- `s_axis_arp_data/user/keep/last/valid` input 64/80/8/1/1: ARP transmit stream.
- `s_axis_arp_ready` output 1: ARP beat accepted when valid&&ready.
- `s_axis_ip_data/user/keep/last/valid` input 64/80/8/1/1: IP transmit stream.
- `s_axis_ip_ready` output 1: IP beat accepted when valid&&ready.
- `m_axis_mac_data/user/keep/last/valid` output 64/80/8/1/1: to MAC transmit.
- `m_axis_mac_ready` input 1: MAC backpressure.
- `o_arp_pkt_cnt` output P_CNT_W: ARP packets fully forwarded.
- `o_ip_pkt_cnt` output P_CNT_W: IP packets fully forwarded.
- `o_busy` output 1: high while state is not IDLE or the output register holds a beat.

## Operation
- FSM states: IDLE, ARP, IP.
- IDLE: both `s_*_ready` = 0. If exactly one source is valid, the next state is that source. If both are valid, the winner follows the arbitration policy (see Configuration).
- ARP/IP: only the granted source's ready may be high, and ready = `!out_valid || m_axis_mac_ready`. An accepted beat is copied into the output register (data, user, keep, last all together). An accepted beat with last=1 sets the next state to IDLE and increments that source's counter by 1.
- The non-granted source's ready stays 0 for the whole packet, even if its valid is high.
- Output register: `m_axis_mac_valid` is set on accept. It is cleared when `m_axis_mac_ready` is high and no new beat is accepted in the same cycle. Contents hold stable while valid&&!ready.
- Counters are P_CNT_W unsigned and wrap from all-ones to 0 with no flag.
- Data, user and keep are never modified. There is no keep or last checking: a source that never asserts last keeps the grant forever.

## Timing
- Reset (async assert, sync release inside): state=IDLE, `m_axis_mac_valid`=0, data/user/keep/last=0, both readys=0, counters=0, `o_busy`=0, last-grant register=IP.
- Reset mid-packet: output is dropped at once (valid falls asynchronously). Partial frame recovery belongs to the MAC.
- Arbitration costs one cycle. Valid seen in IDLE at cycle N gives ready at N+1, and the first beat appears on `m_axis_mac_*` at N+2 at the earliest.
- Throughput: one beat per cycle inside a packet while `m_axis_mac_ready`=1. There is exactly one bubble cycle (IDLE) between back-to-back packets.
- Latency is one cycle from input accept to output valid.
- A counter updates in the cycle after the last beat is accepted. It does not wait for the output handshake.
- Last beat accepted while the other source is already valid: IDLE is entered for one cycle, then the other source is granted.

## Configuration
- `MAC_TX_ARB_RR_EN` defined: round-robin. When both sources are valid in IDLE, grant the source other than the last-grant register. The last-grant register updates on every grant. After reset, ARP wins the first tie.
- `MAC_TX_ARB_RR_EN` undefined: fixed priority, ARP always wins a tie. The last-grant register is not implemented.

## Test plan
- Single ARP packet, 6 beats (last keep=8'h03), ready=1 → 6 identical beats on MAC at N+2..N+7, `o_arp_pkt_cnt`=1, `o_ip_pkt_cnt`=0.
- IP packet of 10 beats in progress, ARP valid at beat 3 → IP finishes uninterrupted, 1 IDLE cycle, then the ARP packet; `s_axis_arp_ready` is 0 throughout the IP packet.
- Both sources continuously valid with 2-beat packets, 8 packets → with `MAC_TX_ARB_RR_EN`: order ARP,IP,ARP,IP…, 4 each; without the macro: 8 ARP, 0 IP.
- `m_axis_mac_ready` toggled randomly (50%) over a 20-beat IP packet → output beat sequence identical to input, no drops or duplicates, and output holds stable while stalled.
- `i_rst` pulled low on beat 4 of 8 → `m_axis_mac_valid`=0 and counters=0 immediately; after release, a new ARP packet is forwarded normally with count 1.
- Counter wrap: 65536 single-beat IP packets → `o_ip_pkt_cnt` returns to 0.
